// File: rtl/reg_file_wb_sink_pkg.sv
// Shared constants and types for the integer register file and its write-back sink.
package rv_rf_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  localparam logic [AW-1:0] REG_X0 = '0;

  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [AW-1:0]   reg_idx_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

  // x0 never holds a value, so a write or busy mark to it is meaningless.
  function automatic logic is_real_reg(input reg_idx_t idx);
    return idx != REG_X0;
  endfunction

endpackage

// File: rtl/reg_file_wb_sink_if.sv
// Decode/write-back port bundle of the register file; master drives, slave serves.
interface reg_file_wb_sink_if;
  import rv_rf_pkg::*;

  logic     wb_reg_we;
  reg_idx_t wb_dstreg_num;
  xlen_t    wb_dstreg_value;
  logic     iss_valid;
  reg_idx_t iss_dstreg_num;
  reg_idx_t dec_rs1_num;
  reg_idx_t dec_rs2_num;
  xlen_t    dec_rs1_value;
  xlen_t    dec_rs2_value;
  logic     dec_rs1_busy;
  logic     dec_rs2_busy;

  modport master (
    output wb_reg_we, wb_dstreg_num, wb_dstreg_value,
    output iss_valid, iss_dstreg_num,
    output dec_rs1_num, dec_rs2_num,
    input  dec_rs1_value, dec_rs2_value, dec_rs1_busy, dec_rs2_busy
  );

  modport slave (
    input  wb_reg_we, wb_dstreg_num, wb_dstreg_value,
    input  iss_valid, iss_dstreg_num,
    input  dec_rs1_num, dec_rs2_num,
    output dec_rs1_value, dec_rs2_value, dec_rs1_busy, dec_rs2_busy
  );

endinterface

// File: rtl/reg_file_wb_sink_scoreboard.sv
// Pending-destination scoreboard: one busy bit per register, issue marks, write-back clears.
module rf_scoreboard
  import rv_rf_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     en_i,
  input  logic     clr_we_i,
  input  reg_idx_t clr_num_i,
  input  logic     set_en_i,
  input  reg_idx_t set_num_i,
  input  reg_idx_t rs1_num_i,
  input  reg_idx_t rs2_num_i,
  output logic     rs1_busy_o,
  output logic     rs2_busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign busy_d[gi] = 1'b0;
      end else begin : g_xn
        logic set_hit;
        logic clr_hit;
        assign set_hit = en_i && set_en_i && (set_num_i == AW'(gi));
        assign clr_hit = en_i && clr_we_i && (clr_num_i == AW'(gi));
        // A new issue to a register that is completing this cycle keeps it pending.
        assign busy_d[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_q[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy_o = en_i && busy_q[rs1_num_i] && !(clr_we_i && (clr_num_i == rs1_num_i));
  assign rs2_busy_o = en_i && busy_q[rs2_num_i] && !(clr_we_i && (clr_num_i == rs2_num_i));

endmodule

// File: rtl/reg_file_wb_sink.sv
// Architectural integer register file: write-back commit, bypassed decode reads,
// busy scoreboard and a post-reset clearing sweep gating rf_ready.
module reg_file_wb_sink
  import rv_rf_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  reg_file_wb_sink_if.slave  rf,
  output logic               rf_ready,
  output logic [31:0]        wb_write_count
);

  rf_state_t state_q, state_d;
  reg_idx_t  clr_idx_q, clr_idx_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  logic     ready;
  logic     commit;
  logic     arr_we;
  reg_idx_t arr_waddr;
  xlen_t    arr_wdata;

  xlen_t regs_q [NREGS];

  assign commit = ready && rf.wb_reg_we && is_real_reg(rf.wb_dstreg_num);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(NREGS - 1)) begin
          state_d = READY;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // The storage has one write port, shared by the sweep and write-back commits.
  always_comb begin
    ready     = 1'b0;
    arr_we    = 1'b0;
    arr_waddr = clr_idx_q;
    arr_wdata = '0;
    case (state_q)
      CLEAR: begin
        arr_we = 1'b1;
      end
      READY: begin
        ready     = 1'b1;
        arr_we    = commit;
        arr_waddr = rf.wb_dstreg_num;
        arr_wdata = rf.wb_dstreg_value;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (commit) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      regs_q[arr_waddr] <= arr_wdata;
    end
  end

  reg_idx_t rs_num [2];
  xlen_t    rs_val [2];

  assign rs_num[0] = rf.dec_rs1_num;
  assign rs_num[1] = rf.dec_rs2_num;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic hit_wb;
      assign hit_wb     = rf.wb_reg_we && (rf.wb_dstreg_num == rs_num[gi]);
      assign rs_val[gi] = (!ready || !is_real_reg(rs_num[gi])) ? '0 :
                          hit_wb ? rf.wb_dstreg_value : regs_q[rs_num[gi]];
    end
  endgenerate

  assign rf.dec_rs1_value = rs_val[0];
  assign rf.dec_rs2_value = rs_val[1];

  rf_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .en_i       (ready),
    .clr_we_i   (rf.wb_reg_we),
    .clr_num_i  (rf.wb_dstreg_num),
    .set_en_i   (rf.iss_valid),
    .set_num_i  (rf.iss_dstreg_num),
    .rs1_num_i  (rf.dec_rs1_num),
    .rs2_num_i  (rf.dec_rs2_num),
    .rs1_busy_o (rf.dec_rs1_busy),
    .rs2_busy_o (rf.dec_rs2_busy)
  );

  assign rf_ready       = ready;
  assign wb_write_count = wr_cnt_q;

endmodule

// File: tb/tb_reg_file_wb_sink.sv
// Self-checking bench for reg_file_wb_sink: directed vector table plus a
// model-driven random phase, expectations queued at drive and popped at sample.
module tb_reg_file_wb_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_ready;
  logic [31:0] wb_write_count;

  reg_file_wb_sink_if rf_if ();

  reg_file_wb_sink dut (
    .clk            (clk),
    .rst            (rst),
    .rf             (rf_if),
    .rf_ready       (rf_ready),
    .wb_write_count (wb_write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wn;
    logic [31:0] wv;
    logic        iss;
    logic [4:0]  in;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
    logic [31:0] ecnt;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
    logic [31:0] ecnt;
  } exp_t;

  vec_t vt [14];
  exp_t exp_q [$];

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wn, input logic [31:0] wv,
                       input logic iss, input logic [4:0] in,
                       input logic [4:0] r1, input logic [4:0] r2);
    rf_if.wb_reg_we       = we;
    rf_if.wb_dstreg_num   = wn;
    rf_if.wb_dstreg_value = wv;
    rf_if.iss_valid       = iss;
    rf_if.iss_dstreg_num  = in;
    rf_if.dec_rs1_num     = r1;
    rf_if.dec_rs2_num     = r2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_busy = 32'd0;
    m_cnt  = 32'd0;
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    logic [4:0] r1;
    logic [4:0] r2;
    logic       we;
    logic [4:0] wn;
    r1 = rf_if.dec_rs1_num;
    r2 = rf_if.dec_rs2_num;
    we = rf_if.wb_reg_we;
    wn = rf_if.wb_dstreg_num;
    e.e1   = (r1 == 5'd0) ? 32'd0 : ((we && wn == r1) ? rf_if.wb_dstreg_value : m_regs[r1]);
    e.e2   = (r2 == 5'd0) ? 32'd0 : ((we && wn == r2) ? rf_if.wb_dstreg_value : m_regs[r2]);
    e.eb1  = m_busy[r1] && !(we && wn == r1);
    e.eb2  = m_busy[r2] && !(we && wn == r2);
    e.ecnt = m_cnt;
    return e;
  endfunction

  task automatic model_update();
    if (rf_if.wb_reg_we) begin
      m_busy[rf_if.wb_dstreg_num] = 1'b0;
      if (rf_if.wb_dstreg_num != 5'd0) begin
        m_regs[rf_if.wb_dstreg_num] = rf_if.wb_dstreg_value;
        m_cnt = m_cnt + 32'd1;
      end
    end
    if (rf_if.iss_valid && rf_if.iss_dstreg_num != 5'd0) m_busy[rf_if.iss_dstreg_num] = 1'b1;
  endtask

  task automatic sample_compare(input string tag);
    exp_t e;
    @(negedge clk);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: got no queued expectation expected one", tag);
      return;
    end
    n_vec--;
    e = exp_q.pop_front();
    $display("%s: we=%0b wn=%0d iss=%0b in=%0d rs1=%0d->%h/%0b rs2=%0d->%h/%0b cnt=%0d",
             tag, rf_if.wb_reg_we, rf_if.wb_dstreg_num, rf_if.iss_valid, rf_if.iss_dstreg_num,
             rf_if.dec_rs1_num, rf_if.dec_rs1_value, rf_if.dec_rs1_busy,
             rf_if.dec_rs2_num, rf_if.dec_rs2_value, rf_if.dec_rs2_busy, wb_write_count);
    chk({tag, " rs1_val"}, rf_if.dec_rs1_value, e.e1);
    chk({tag, " rs2_val"}, rf_if.dec_rs2_value, e.e2);
    chk({tag, " rs1_busy"}, {31'd0, rf_if.dec_rs1_busy}, {31'd0, e.eb1});
    chk({tag, " rs2_busy"}, {31'd0, rf_if.dec_rs2_busy}, {31'd0, e.eb2});
    chk({tag, " count"}, wb_write_count, e.ecnt);
  endtask

  task automatic cycle_end();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Counts edges until rf_ready; optionally fires write-back/issue traffic during the sweep.
  task automatic wait_ready(input logic inject, output int cyc);
    cyc = 0;
    while (!rf_ready && cyc < 100) begin
      if (inject && cyc < 5) drive(1'b1, 5'd3, 32'hFF, 1'b1, 5'd9, 5'd3, 5'd9);
      else                   drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd9);
      if (cyc < 3) begin
        @(negedge clk);
        chk("clear_rs1_val", rf_if.dec_rs1_value, 32'd0);
        chk("clear_rs2_busy", {31'd0, rf_if.dec_rs2_busy}, 32'd0);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(i), 5'(31 - i));
      @(negedge clk);
      chk({tag, " rs1_val"}, rf_if.dec_rs1_value, 32'd0);
      chk({tag, " rs2_val"}, rf_if.dec_rs2_value, 32'd0);
      chk({tag, " rs1_busy"}, {31'd0, rf_if.dec_rs1_busy}, 32'd0);
      chk({tag, " rs2_busy"}, {31'd0, rf_if.dec_rs2_busy}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic random_phase(input int n, input string tag);
    logic [4:0] wn;
    logic [4:0] in;
    logic [4:0] r1;
    logic [4:0] r2;
    for (int k = 0; k < n; k++) begin
      wn = 5'($urandom_range(0, 31));
      in = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? in : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wn, $urandom, 1'($urandom_range(0, 1)), in, r1, r2);
      exp_q.push_back(model_expect());
      sample_compare(tag);
      cycle_end();
    end
  endtask

  initial begin
    int   cyc;
    exp_t e;

    vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0,        1'b0, 1'b0, 32'd0};
    vt[1]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'd1};
    vt[2]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 5'd0, 5'd5, 32'd0,        32'hDEADBEEF, 1'b0, 1'b0, 32'd1};
    vt[3]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 5'd0, 5'd0, 32'd0,        32'd0,        1'b0, 1'b0, 32'd1};
    vt[4]  = '{1'b0, 5'd0, 32'd0,        1'b1, 5'd7, 5'd5, 5'd7, 32'hDEADBEEF, 32'd0,        1'b0, 1'b0, 32'd1};
    vt[5]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 32'd0,        1'b0, 1'b1, 32'd1};
    vt[6]  = '{1'b1, 5'd7, 32'h55,       1'b0, 5'd0, 5'd7, 5'd7, 32'h55,       32'h55,       1'b0, 1'b0, 32'd1};
    vt[7]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 32'h55,       1'b0, 1'b0, 32'd2};
    vt[8]  = '{1'b1, 5'd7, 32'h66,       1'b1, 5'd7, 5'd7, 5'd7, 32'h66,       32'h66,       1'b0, 1'b0, 32'd2};
    vt[9]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h66,       32'h66,       1'b1, 1'b1, 32'd3};
    vt[10] = '{1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 5'd7, 5'd7, 32'h77,       32'h77,       1'b0, 1'b0, 32'd3};
    vt[11] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 5'd7, 5'd3, 32'h77,       32'd0,        1'b0, 1'b0, 32'd4};
    vt[12] = '{1'b0, 5'd0, 32'd0,        1'b1, 5'd0, 5'd0, 5'd9, 32'd0,        32'd0,        1'b0, 1'b0, 32'd4};
    vt[13] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 5'd0, 5'd9, 32'd0,        32'd0,        1'b0, 1'b0, 32'd4};

    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, rf_ready}, 32'd0);
    chk("reset_count", wb_write_count, 32'd0);
    rst = 1'b0;

    // Sweep with write-back x3 and issue x9 traffic that must be ignored.
    wait_ready(1'b1, cyc);
    chk("ready_latency", 32'(cyc), 32'd32);
    check_all_zero("post_reset");
    model_reset();

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].we, vt[i].wn, vt[i].wv, vt[i].iss, vt[i].in, vt[i].r1, vt[i].r2);
      e.e1 = vt[i].e1; e.e2 = vt[i].e2; e.eb1 = vt[i].eb1; e.eb2 = vt[i].eb2; e.ecnt = vt[i].ecnt;
      exp_q.push_back(e);
      sample_compare($sformatf("vec%0d", i));
      cycle_end();
    end

    random_phase(150, "rnd");

    // Reset while READY: asynchronous effect, then again partway through the sweep.
    rst = 1'b1;
    #1;
    chk("ready_rst_count", wb_write_count, 32'd0);
    chk("ready_rst_ready", {31'd0, rf_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midsweep_ready", {31'd0, rf_ready}, 32'd0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    wait_ready(1'b0, cyc);
    chk("restart_latency", 32'(cyc), 32'd32);
    chk("restart_count", wb_write_count, 32'd0);
    check_all_zero("post_restart");
    model_reset();
    random_phase(40, "rnd2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
